// File: rtl/ftdi_rst_seq_pkg.sv
// Shared types and constants for the UMFT601A reset sequencer: FSM state codes,
// register map, register bit positions and the reset-bundle encoding per state.
package ftdi_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ASSERT     = 3'd1,
    ST_CHIP_HOLD  = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_WAIT_READY = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERROR      = 3'd6
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_HOLD   = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

  localparam int CTRL_START_BIT      = 0;
  localparam int CTRL_FORCE_HOLD_BIT = 1;
  localparam int CTRL_CLR_ERR_BIT    = 2;

  localparam int STAT_BUSY_BIT       = 4;
  localparam int STAT_DONE_BIT       = 5;
  localparam int STAT_TIMEOUT_BIT    = 6;
  localparam int STAT_READY_LOST_BIT = 7;

  // out_port[1] = FT601 chip reset, out_port[0] = controller-logic reset
  localparam logic [1:0] OUT_BOTH  = 2'b11;
  localparam logic [1:0] OUT_LOGIC = 2'b01;
  localparam logic [1:0] OUT_NONE  = 2'b00;

  function automatic logic [1:0] out_port_for(state_t s);
    case (s)
      ST_SETTLE, ST_ERROR:     return OUT_LOGIC;
      ST_WAIT_READY, ST_DONE:  return OUT_NONE;
      default:                 return OUT_BOTH;
    endcase
  endfunction

  function automatic logic is_busy(state_t s);
    return (s == ST_ASSERT) || (s == ST_CHIP_HOLD) ||
           (s == ST_SETTLE) || (s == ST_WAIT_READY);
  endfunction

endpackage

// File: rtl/ftdi_umft601a_reset_sequencer_if.sv
// Avalon-MM register port of the UMFT601A reset sequencer (zero wait states).
interface ftdi_umft601a_reset_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ftdi_rst_seq_timer.sv
// Loadable up-counter with terminal-count compare; shared by the hold, settle
// and ready-timeout phases of the reset sequencer.
module ftdi_rst_seq_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/ftdi_umft601a_reset_sequencer.sv
// Timed reset sequencer for the FTDI UMFT601A 2-bit reset bundle, Avalon-MM slave.
// Optional interrupt output enabled by defining FTDI_RST_SEQ_IRQ_EN.
module ftdi_umft601a_reset_sequencer
  import ftdi_rst_seq_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int HOLD_DEFAULT   = 1000,
  parameter int SETTLE_CYCLES  = 500,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int AUTO_START     = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ftdi_umft601a_reset_sequencer_if.slave bus,
  input  logic                          ftdi_ready,
  output logic [1:0]                    out_port,
  output logic                          irq
);

  // Terminal counts are "cycles - 1" because the timer starts at 0 on phase entry
  localparam logic [CNT_W-1:0] HOLD_RST     = CNT_W'(HOLD_DEFAULT);
  localparam logic [CNT_W-1:0] SETTLE_TERM  = CNT_W'((SETTLE_CYCLES  > 1) ? SETTLE_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state, state_next;
  logic             auto_pend;
  logic [CNT_W-1:0] hold_reg;
  logic [CNT_W-1:0] hold_term;
  logic             force_hold;
  logic             done, timeout_err, ready_lost;
  logic             wr_en, ctrl_wr, start_req, clr_err_req, force_now, start_ok;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_term;
  logic [31:0]      rdata;
  logic             irq_en_bit;
  logic             unused_wdata;

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign ctrl_wr     = wr_en && (bus.address == ADDR_CTRL);
  assign start_req   = ctrl_wr & bus.writedata[CTRL_START_BIT];
  assign clr_err_req = ctrl_wr & bus.writedata[CTRL_CLR_ERR_BIT];
  // A force_hold write acts on the same edge it is written, not one cycle later
  assign force_now   = ctrl_wr ? bus.writedata[CTRL_FORCE_HOLD_BIT] : force_hold;
  assign start_ok    = start_req & ~force_now & ~is_busy(state);
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    state_next = state;
    if (force_now) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (start_ok || auto_pend) state_next = ST_ASSERT;
        ST_ASSERT:     state_next = ST_CHIP_HOLD;
        ST_CHIP_HOLD:  if (tmr_tc) state_next = ST_SETTLE;
        ST_SETTLE:     if (tmr_tc) state_next = ST_WAIT_READY;
        ST_WAIT_READY: begin
          if (ftdi_ready)  state_next = ST_DONE;
          else if (tmr_tc) state_next = ST_ERROR;
        end
        ST_DONE, ST_ERROR: if (start_ok) state_next = ST_ASSERT;
        default:       state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tmr_term = '0;
    case (state)
      ST_CHIP_HOLD:  tmr_term = hold_term;
      ST_SETTLE:     tmr_term = SETTLE_TERM;
      ST_WAIT_READY: tmr_term = TIMEOUT_TERM;
      default:       tmr_term = '0;
    endcase
  end

  assign tmr_clr = (state_next != state) | force_now;
  assign tmr_en  = is_busy(state);

  ftdi_rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .tc      (tmr_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      auto_pend <= (AUTO_START != 0);
    end else begin
      state     <= state_next;
      auto_pend <= 1'b0;
    end
  end

  // HOLD is captured on the way into CHIP_HOLD; a zero hold behaves as one cycle
  always_ff @(posedge clk) begin
    if (state == ST_ASSERT) begin
      hold_term <= (hold_reg == '0) ? '0 : hold_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg   <= HOLD_RST;
      force_hold <= 1'b0;
    end else begin
      if (wr_en && (bus.address == ADDR_HOLD)) hold_reg <= bus.writedata[CNT_W-1:0];
      if (ctrl_wr) force_hold <= bus.writedata[CTRL_FORCE_HOLD_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      ready_lost  <= 1'b0;
    end else begin
      if (start_ok)                                            done <= 1'b0;
      else if ((state_next == ST_DONE) && (state != ST_DONE))  done <= 1'b1;

      if ((state == ST_WAIT_READY) && (state_next == ST_ERROR)) timeout_err <= 1'b1;
      else if (clr_err_req)                                     timeout_err <= 1'b0;

      if (start_ok)                                 ready_lost <= 1'b0;
      else if ((state == ST_DONE) && !ftdi_ready)   ready_lost <= 1'b1;
    end
  end

`ifdef FTDI_RST_SEQ_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && (bus.address == ADDR_IRQ_EN)) irq_en <= bus.writedata[0];
      if (start_ok || clr_err_req) irq <= 1'b0;
      else                         irq <= irq_en & (done | timeout_err | ready_lost);
    end
  end

  assign irq_en_bit = irq_en;
`else
  assign irq        = 1'b0;
  assign irq_en_bit = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_CTRL:   rdata[CTRL_FORCE_HOLD_BIT] = force_hold;
      ADDR_STATUS: begin
        rdata[3:0]                 = {1'b0, state};
        rdata[STAT_BUSY_BIT]       = is_busy(state);
        rdata[STAT_DONE_BIT]       = done;
        rdata[STAT_TIMEOUT_BIT]    = timeout_err;
        rdata[STAT_READY_LOST_BIT] = ready_lost;
      end
      ADDR_HOLD:   rdata[CNT_W-1:0] = hold_reg;
      ADDR_IRQ_EN: rdata[0] = irq_en_bit;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_port_for(state);

endmodule

// File: tb/tb_ftdi_umft601a_reset_sequencer.sv
// Scoreboard bench for the UMFT601A reset sequencer: every register read pushes
// its expected readdata/out_port/irq; a negedge monitor pops and compares.
module tb_ftdi_umft601a_reset_sequencer;

  localparam int CNT_W   = 24;
  localparam int HOLD_D  = 4;
  localparam int SETTLE  = 3;
  localparam int TIMEOUT = 16;

`ifdef FTDI_RST_SEQ_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ftdi_ready = 1'b1;
  logic [1:0] out_port;
  logic       irq;

  ftdi_umft601a_reset_sequencer_if bus ();

  ftdi_umft601a_reset_sequencer #(
    .CNT_W          (CNT_W),
    .HOLD_DEFAULT   (HOLD_D),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .AUTO_START     (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .ftdi_ready (ftdi_ready),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  outp;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic ie(logic v);
    return v & IRQ_BUILD;
  endfunction

  task automatic check(string tag, string what, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.chipselect && bus.write_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got read of addr %0d expected none", bus.address);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, "readdata", bus.readdata, e.data);
        check(e.tag, "out_port", {30'd0, out_port}, {30'd0, e.outp});
        check(e.tag, "irq", {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  task automatic rd(string tag, logic [1:0] a, logic [31:0] d, logic [1:0] o, logic i);
    exp_q.push_back('{tag: tag, data: d, outp: o, irq: i});
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic st(string tag, int n, logic [31:0] d, logic [1:0] o, logic i);
    for (int k = 0; k < n; k++) rd(tag, 2'd1, d, o, i);
  endtask

  // Full auto-started sequence with HOLD=HOLD_D and ready already high
  task automatic auto_seq(string pfx);
    st({pfx, "_idle"},   1, 32'h00, 2'b11, 1'b0);
    st({pfx, "_assert"}, 1, 32'h11, 2'b11, 1'b0);
    st({pfx, "_chip"},   HOLD_D, 32'h12, 2'b11, 1'b0);
    st({pfx, "_settle"}, SETTLE, 32'h13, 2'b01, 1'b0);
    st({pfx, "_wait"},   1, 32'h14, 2'b00, 1'b0);
    st({pfx, "_done"},   1, 32'h25, 2'b00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    rd("rst_status", 2'd1, 32'h00, 2'b11, 1'b0);
    rd("rst_hold",   2'd2, HOLD_D, 2'b11, 1'b0);
    rd("rst_ctrl",   2'd0, 32'h00, 2'b11, 1'b0);
    rd("rst_irqen",  2'd3, 32'h00, 2'b11, 1'b0);
    reset_n = 1'b1;
    auto_seq("auto");

    // Ready drops while DONE; interrupt enable afterwards
    ftdi_ready = 1'b0;
    st("lost_pre", 1, 32'h25, 2'b00, 1'b0);
    st("lost_set", 1, 32'hA5, 2'b00, 1'b0);
    wr(2'd3, 32'h1);
    rd("irqen_rb", 2'd3, {31'd0, ie(1'b1)}, 2'b00, 1'b0);
    st("irq_rise", 1, 32'hA5, 2'b00, ie(1'b1));

    // force_hold to IDLE, start ignored while held, then HOLD=0 run into timeout
    wr(2'd0, 32'h2);
    st("force_idle", 1, 32'hA0, 2'b11, ie(1'b1));
    rd("ctrl_rb", 2'd0, 32'h2, 2'b11, ie(1'b1));
    wr(2'd0, 32'h3);
    st("force_start_ign", 1, 32'hA0, 2'b11, ie(1'b1));
    wr(2'd2, 32'h0);
    rd("hold0_rb", 2'd2, 32'h0, 2'b11, ie(1'b1));
    wr(2'd0, 32'h0);
    st("force_clr_idle", 1, 32'hA0, 2'b11, ie(1'b1));
    wr(2'd0, 32'h1);
    st("h0_assert", 1, 32'h11, 2'b11, 1'b0);
    st("h0_chip",   1, 32'h12, 2'b11, 1'b0);
    st("h0_settle", SETTLE, 32'h13, 2'b01, 1'b0);
    st("to_wait",   TIMEOUT, 32'h14, 2'b00, 1'b0);
    st("to_err",     1, 32'h46, 2'b01, 1'b0);
    st("to_err_irq", 1, 32'h46, 2'b01, ie(1'b1));

    // clr_err + start together, then force_hold during SETTLE
    wr(2'd0, 32'h5);
    st("clr_assert", 1, 32'h11, 2'b11, 1'b0);
    st("clr_chip",   1, 32'h12, 2'b11, 1'b0);
    st("clr_settle", 1, 32'h13, 2'b01, 1'b0);
    wr(2'd0, 32'h2);
    st("fh_idle", 1, 32'h00, 2'b11, 1'b0);
    wr(2'd0, 32'h3);
    st("fh_start_ign", 1, 32'h00, 2'b11, 1'b0);
    ftdi_ready = 1'b1;
    wr(2'd0, 32'h0);
    st("fh_released", 1, 32'h00, 2'b11, 1'b0);
    wr(2'd0, 32'h1);
    st("re_assert", 1, 32'h11, 2'b11, 1'b0);
    st("re_chip",   1, 32'h12, 2'b11, 1'b0);
    st("re_settle", SETTLE, 32'h13, 2'b01, 1'b0);
    st("re_wait",   1, 32'h14, 2'b00, 1'b0);
    st("re_done",   1, 32'h25, 2'b00, 1'b0);
    st("re_done_irq", 1, 32'h25, 2'b00, ie(1'b1));

    // Asynchronous reset during CHIP_HOLD restores defaults and reruns
    wr(2'd2, 32'h7);
    rd("hold7_rb", 2'd2, 32'h7, 2'b00, ie(1'b1));
    wr(2'd0, 32'h1);
    st("rs_assert", 1, 32'h11, 2'b11, 1'b0);
    st("rs_chip",   1, 32'h12, 2'b11, 1'b0);
    reset_n = 1'b0;
    st("rs_async", 1, 32'h00, 2'b11, 1'b0);
    rd("rs_hold",  2'd2, HOLD_D, 2'b11, 1'b0);
    rd("rs_irqen", 2'd3, 32'h0, 2'b11, 1'b0);
    reset_n = 1'b1;
    auto_seq("rerun");

    @(negedge clk);
    check("end", "pending_expectations", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
